dir_queue: RTL

- Turns the single-cycle button pulses from the four debounced direction buttons into the snake's heading.
- Buffers legal turn requests in a small FIFO and filters out no-op and 180° reversal requests.
- Applies one queued turn per game-step tick.
- Sits between the button conditioning stage and the snake movement/collision logic.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/dir_fifo.sv | 81 ++++++++
 rtl/dir_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared snake-game definitions: the 2-bit heading type, the
//                four heading codes and the opposite-heading helper. Used by
//                the direction queue, movement and renderer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // The encoding puts opposite headings two apart, so flipping bit 1
  // yields the reverse direction.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dir_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dir_fifo
//  Description : DEPTH x 2-bit synchronous FIFO of pending headings with
//                simultaneous push/pop. Exposes the head entry, the most
//                recently written entry, occupancy and full/empty flags.
//                The parent must not pop when empty, nor push when full
//                unless a pop happens in the same cycle.
//  Ports       : clk, reset (async, active-low), clear (sync flush)
//                i_push/i_data  - write i_data at the tail
//                i_pop          - remove the head entry
//                o_head, o_tail - oldest / newest stored entry
//                o_level, o_full, o_empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [1:0]               i_data,
  output logic [1:0]               o_head,
  output logic [1:0]               o_tail,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

  dir_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [AW-1:0] w_tail_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;   // power-of-2 depth: natural wrap
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Newest entry sits just behind the write pointer.
  assign w_tail_idx = r_wptr - 1'b1;

  assign o_head  = r_mem[r_rptr];
  assign o_tail  = r_mem[w_tail_idx];
  assign o_level = r_level;
  assign o_full  = (r_level == C_FULL);
  assign o_empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/dir_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dir_queue
//  Description : Converts direction button pulses into the snake heading.
//                Legal turns are queued; no-op and reversal requests are
//                dropped; one queued turn is applied per game tick.
//  Ports       : clk, reset (async, active-low), clear (sync restart)
//                btn_up/right/down/left - one-cycle request pulses
//                tick     - game-step strobe
//                dir      - current heading (00 U, 01 R, 10 D, 11 L)
//                turned   - pulse: dir changed on the last tick
//                dropped  - pulse: request was same/opposite direction
//                overflow - pulse: legal request lost, queue full
//                level    - queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_queue
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter dir_t INIT_DIR = DIR_RIGHT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   btn_up,
  input  logic                   btn_right,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   tick,
  output logic [1:0]             dir,
  output logic                   turned,
  output logic                   dropped,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  dir_t w_cand;
  dir_t w_last;
  dir_t w_head;
  dir_t w_tail;
  logic w_req;
  logic w_reject;
  logic w_pop;
  logic w_push;
  logic w_lost;
  logic w_full;
  logic w_empty;

  dir_t r_dir;
  logic r_turned;
  logic r_dropped;
  logic r_overflow;

  // Fixed-priority encode; lower-priority simultaneous presses vanish.
  always_comb begin
    w_cand = DIR_LEFT;
    if (btn_up)         w_cand = DIR_UP;
    else if (btn_right) w_cand = DIR_RIGHT;
    else if (btn_down)  w_cand = DIR_DOWN;
  end

  assign w_req = btn_up | btn_right | btn_down | btn_left;

  // Filter against the heading the snake will have once the queue drains,
  // so a pending turn can't be followed by its own reversal.
  assign w_last   = w_empty ? r_dir : w_tail;
  assign w_reject = (w_cand == w_last) || (w_cand == opposite(w_last));

  // A pop frees a slot in the same cycle, so a full queue may still accept.
  assign w_pop  = tick & ~w_empty & ~clear;
  assign w_push = w_req & ~w_reject & (~w_full | w_pop) & ~clear;
  assign w_lost = w_req & ~w_reject & w_full & ~w_pop;

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cand),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir      <= INIT_DIR;
      r_turned   <= 1'b0;
      r_dropped  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_dir      <= INIT_DIR;
      r_turned   <= 1'b0;
      r_dropped  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_dir <= w_head;
      end
      r_turned   <= w_pop;
      r_dropped  <= w_req & w_reject;
      r_overflow <= w_lost;
    end
  end

  assign dir      = r_dir;
  assign turned   = r_turned;
  assign dropped  = r_dropped;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
